// File: rtl/friscv_ram_arbiter.sv
// Round-robin arbiter sharing one byte-enable RAM port between two requesters.
// Grants are combinational; each requester has one outstanding read and a registered response slot.
module friscv_ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic                    req0_wren,
    input  logic [DATA_WIDTH/8-1:0] req0_wbe,
    input  logic [ADDR_WIDTH-1:0]   req0_addr,
    input  logic [DATA_WIDTH-1:0]   req0_wdata,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic                    req1_wren,
    input  logic [DATA_WIDTH/8-1:0] req1_wbe,
    input  logic [ADDR_WIDTH-1:0]   req1_addr,
    input  logic [DATA_WIDTH-1:0]   req1_wdata,
    output logic                    rsp0_valid,
    input  logic                    rsp0_ready,
    output logic [DATA_WIDTH-1:0]   rsp0_rdata,
    output logic                    rsp1_valid,
    input  logic                    rsp1_ready,
    output logic [DATA_WIDTH-1:0]   rsp1_rdata,
    output logic                    ram_wren,
    output logic [DATA_WIDTH/8-1:0] ram_wbe,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    typedef enum logic {
        PTR_REQ0 = 1'b0,
        PTR_REQ1 = 1'b1
    } rr_ptr_t;

    rr_ptr_t                 rr_ptr;
    logic [1:0]              inflight;
    logic [1:0]              eligible;
    logic [1:0]              want;
    logic [1:0]              grant;
    rr_ptr_t                 sel;
    logic                    sel_wren;
    logic [DATA_WIDTH/8-1:0] sel_wbe;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        eligible    = 2'b00;
        want        = 2'b00;
        grant       = 2'b00;
        eligible[0] = req0_wren | (!inflight[0] & (!rsp0_valid | rsp0_ready));
        eligible[1] = req1_wren | (!inflight[1] & (!rsp1_valid | rsp1_ready));
        // Nothing is granted while reset is held, so the RAM sees no writes.
        want        = {req1_valid, req0_valid} & eligible & {2{aresetn}};
        grant[0]    = want[0] & (!want[1] | (rr_ptr == PTR_REQ0));
        grant[1]    = want[1] & (!want[0] | (rr_ptr == PTR_REQ1));
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Idle cycles still mux the pointed requester onto addr/wdata.
    always_comb begin
        sel = rr_ptr;
        if (grant[0]) begin
            sel = PTR_REQ0;
        end else if (grant[1]) begin
            sel = PTR_REQ1;
        end
        sel_wren  = (sel == PTR_REQ1) ? req1_wren  : req0_wren;
        sel_wbe   = (sel == PTR_REQ1) ? req1_wbe   : req0_wbe;
        ram_addr  = (sel == PTR_REQ1) ? req1_addr  : req0_addr;
        ram_wdata = (sel == PTR_REQ1) ? req1_wdata : req0_wdata;
        ram_wren  = (|grant) & sel_wren;
        ram_wbe   = ram_wren ? sel_wbe : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr   <= PTR_REQ0;
            inflight <= 2'b00;
        end else begin
            if (grant[0]) begin
                rr_ptr <= PTR_REQ1;
            end else if (grant[1]) begin
                rr_ptr <= PTR_REQ0;
            end
            inflight <= grant & ~{req1_wren, req0_wren};
        end
    end

    // A slot can only fill when its read was granted, which required the slot
    // to be empty or draining, so fill and drain never conflict.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
        end else if (inflight[0]) begin
            rsp0_valid <= 1'b1;
            rsp0_rdata <= ram_rdata;
        end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
        end else if (inflight[1]) begin
            rsp1_valid <= 1'b1;
            rsp1_rdata <= ram_rdata;
        end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_friscv_ram_arbiter.sv
// Directed bench for friscv_ram_arbiter with a behavioural RAM and a
// response scoreboard drained by an independent monitor.
module tb_friscv_ram_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        req0_valid, req0_ready, req0_wren;
    logic [3:0]  req0_wbe;
    logic [7:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic        req1_valid, req1_ready, req1_wren;
    logic [3:0]  req1_wbe;
    logic [7:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        ram_wren;
    logic [3:0]  ram_wbe;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [256];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 aclk = ~aclk;

    friscv_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wren(req0_wren),
        .req0_wbe(req0_wbe), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wren(req1_wren),
        .req1_wbe(req1_wbe), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
        .ram_wren(ram_wren), .ram_wbe(ram_wbe), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Byte-enable RAM port with registered output (one-cycle read latency).
    always @(posedge aclk) begin
        if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wbe[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic w, input logic [3:0] be,
                          input logic [7:0] a, input logic [31:0] d);
        req0_valid = v; req0_wren = w; req0_wbe = be; req0_addr = a; req0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic w, input logic [3:0] be,
                          input logic [7:0] a, input logic [31:0] d);
        req1_valid = v; req1_wren = w; req1_wbe = be; req1_addr = a; req1_wdata = d;
    endtask

    // Single-requester access on port 0: must be granted immediately.
    task automatic solo0(input logic w, input logic [3:0] be, input logic [7:0] a,
                         input logic [31:0] d, input string name);
        drive0(1'b1, w, be, a, d);
        @(negedge aclk);
        check(name, 32'(req0_ready), 32'd1);
        tick;
        drive0(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        logic [31:0] exp_data;
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                if (rsp0_valid && rsp0_ready) begin
                    if (q0.size() == 0) begin
                        n_checks++;
                        $display("FAIL rsp0_unexpected: got response %h, expected none at %0t", rsp0_rdata, $time);
                    end else begin
                        exp_data = q0.pop_front();
                        check("rsp0_rdata", rsp0_rdata, exp_data);
                    end
                end
                if (rsp1_valid && rsp1_ready) begin
                    if (q1.size() == 0) begin
                        n_checks++;
                        $display("FAIL rsp1_unexpected: got response %h, expected none at %0t", rsp1_rdata, $time);
                    end else begin
                        exp_data = q1.pop_front();
                        check("rsp1_rdata", rsp1_rdata, exp_data);
                    end
                end
            end
        end
    end

    initial begin
        logic exp_grant [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

        aresetn    = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive0(1'b1, 1'b1, 4'h0, 8'h00, 32'h0);
        drive1(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);

        // Reset state with a pending request.
        repeat (2) @(negedge aclk);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("rst_ram_wren", 32'(ram_wren), 32'd0);
        check("rst_ram_wbe", 32'(ram_wbe), 32'd0);
        check("rst_rsp0_rdata", rsp0_rdata, 32'd0);
        tick;
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst_req0_ready", 32'(req0_ready), 32'd1);
        tick;
        drive0(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);

        // Single write then read of the same word; check response latency.
        drive0(1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
        @(negedge aclk);
        check("wr_ready", 32'(req0_ready), 32'd1);
        check("wr_ram_wren", 32'(ram_wren), 32'd1);
        check("wr_ram_wbe", 32'(ram_wbe), 32'hF);
        check("wr_ram_addr", 32'(ram_addr), 32'h10);
        tick;
        drive0(1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
        @(negedge aclk);
        check("rd_ready", 32'(req0_ready), 32'd1);
        check("rd_ram_wren", 32'(ram_wren), 32'd0);
        q0.push_back(32'hDEADBEEF);
        tick;
        drive0(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        @(negedge aclk);
        check("rd_lat_c1_valid", 32'(rsp0_valid), 32'd0);
        tick;
        @(negedge aclk);
        check("rd_lat_c2_valid", 32'(rsp0_valid), 32'd1);
        tick;

        // Partial byte-enable write merges into the existing word.
        solo0(1'b1, 4'hF, 8'h20, 32'h11223344, "be_full_wr");
        solo0(1'b1, 4'b0010, 8'h20, 32'h0000AA00, "be_part_wr");
        solo0(1'b1, 4'h0, 8'h20, 32'hFFFFFFFF, "be_zero_wr");
        q0.push_back(32'h1122AA44);
        solo0(1'b0, 4'h0, 8'h20, 32'h0, "be_rd");
        repeat (2) tick;

        // Requester 1 alone leaves the pointer on requester 0.
        drive1(1'b1, 1'b1, 4'hF, 8'h30, 32'h30303030);
        @(negedge aclk);
        check("solo1_ready", 32'(req1_ready), 32'd1);
        tick;

        // Both writing every cycle: grants alternate starting with 0.
        drive0(1'b1, 1'b1, 4'hF, 8'h40, 32'hA0A0A0A0);
        drive1(1'b1, 1'b1, 4'hF, 8'h41, 32'hB1B1B1B1);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            check("rr_req0_ready", 32'(req0_ready), 32'(exp_grant[i] == 1'b0));
            check("rr_req1_ready", 32'(req1_ready), 32'(exp_grant[i] == 1'b1));
            tick;
        end

        // Requester 0 alone, then a tie goes to requester 1.
        drive1(1'b0, 1'b1, 4'hF, 8'h41, 32'hB1B1B1B1);
        @(negedge aclk);
        check("solo0_ready", 32'(req0_ready), 32'd1);
        tick;
        drive1(1'b1, 1'b1, 4'hF, 8'h41, 32'hB1B1B1B1);
        @(negedge aclk);
        check("tie_req1_ready", 32'(req1_ready), 32'd1);
        check("tie_req0_ready", 32'(req0_ready), 32'd0);
        tick;
        drive0(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drive1(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);

        // Backpressure on response slot 1.
        rsp1_ready = 1'b0;
        drive1(1'b1, 1'b0, 4'h0, 8'h41, 32'h0);
        @(negedge aclk);
        check("bp_rd1_ready", 32'(req1_ready), 32'd1);
        q1.push_back(32'hB1B1B1B1);
        tick;
        drive1(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        tick;
        drive1(1'b1, 1'b0, 4'h0, 8'h30, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive0(1'b1, 1'b1, 4'hF, 8'h50, 32'h50500000 + 32'(i));
            @(negedge aclk);
            check("bp_rsp1_valid", 32'(rsp1_valid), 32'd1);
            check("bp_rsp1_rdata", rsp1_rdata, 32'hB1B1B1B1);
            check("bp_req1_blocked", 32'(req1_ready), 32'd0);
            check("bp_req0_granted", 32'(req0_ready), 32'd1);
            tick;
        end
        rsp1_ready = 1'b1;
        @(negedge aclk);
        check("bp_release_req1_ready", 32'(req1_ready), 32'd1);
        q1.push_back(32'h30303030);
        tick;
        drive0(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        drive1(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        repeat (3) tick;

        // Read back the contention and backpressure writes.
        q0.push_back(32'hA0A0A0A0);
        solo0(1'b0, 4'h0, 8'h40, 32'h0, "rb_rd40");
        repeat (2) tick;
        q0.push_back(32'h50500002);
        solo0(1'b0, 4'h0, 8'h50, 32'h0, "rb_rd50");
        repeat (2) tick;

        // Reset in the cycle after a read grant drops the read.
        solo0(1'b0, 4'h0, 8'h10, 32'h0, "mid_rd");
        aresetn = 1'b0;
        repeat (2) tick;
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            check("mid_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
            tick;
        end

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
